// File: rtl/dphy_sync_aligner_if.sv
// Lane-side bundle of the D-PHY HS sync aligner.
// master drives the lane samples, slave is the aligner.
interface dphy_sync_aligner_if;
  logic       hs_enable;
  logic [1:0] din;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       sync_found;
  logic       locked;
  logic       bit_offset;
  logic       sync_err;

  modport master (
    output hs_enable,
    output din,
    input  byte_out,
    input  byte_valid,
    input  sync_found,
    input  locked,
    input  bit_offset,
    input  sync_err
  );

  modport slave (
    input  hs_enable,
    input  din,
    output byte_out,
    output byte_valid,
    output sync_found,
    output locked,
    output bit_offset,
    output sync_err
  );
endinterface

// File: rtl/dphy_sync_aligner.sv
// Per-lane HS sync hunter and byte aligner, dphy_clk domain.
// Takes 2 bits per clock (din[0] first) and emits bytes every 4 clocks.
module dphy_sync_aligner #(
  parameter logic [7:0] SYNC_BYTE    = 8'hB8,
  parameter int         LEADER_ZEROS = 2,
  parameter int         HUNT_TIMEOUT = 1024
) (
  input logic                dphy_clk,
  input logic                areset,
  dphy_sync_aligner_if.slave lane
);

  localparam int CW = $clog2(HUNT_TIMEOUT + 1);
  localparam int LM = (1 << LEADER_ZEROS) - 1;
  localparam logic [15:0] LMASK0 = 16'(LM << (8 - LEADER_ZEROS));
  localparam logic [15:0] LMASK1 = LMASK0 >> 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HUNT_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(HUNT_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    HUNT,
    LOCKED,
    FAIL
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   hist_q, hist_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    phase_q, phase_d;
  logic          off_q, off_d;
  logic [7:0]    byte_q, byte_d;
  logic          bv_q, bv_d;
  logic          sf_q, sf_d;
  logic          se_q, se_d;

  logic       match0;
  logic       match1;
  logic       timeout;
  logic       run_q;
  logic       run_d;
  logic [7:0] win;

  assign match0 = (hist_q[15:8] == SYNC_BYTE)
               && ((hist_q & LMASK0) == 16'h0);
  assign match1 = (hist_q[14:7] == SYNC_BYTE)
               && ((hist_q & LMASK1) == 16'h0);
  assign timeout = (cnt_q == CNT_LAST);
  assign win = off_q ? hist_q[14:7] : hist_q[15:8];

  // Next state, counters and registered output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    phase_d = '0;
    off_d   = off_q;
    byte_d  = byte_q;
    bv_d    = 1'b0;
    sf_d    = 1'b0;
    se_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (lane.hs_enable) state_d = HUNT;
      end
      HUNT: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q
              : cnt_q + CW'(1);
        if (!lane.hs_enable) begin
          state_d = IDLE;
        end else if (match0 || match1) begin
          state_d = LOCKED;
          off_d   = !match0;
          sf_d    = 1'b1;
        end else if (timeout) begin
          state_d = FAIL;
          se_d    = 1'b1;
        end
      end
      LOCKED: begin
        if (!lane.hs_enable) begin
          state_d = IDLE;
        end else begin
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd3) begin
            bv_d   = 1'b1;
            byte_d = win;
          end
        end
      end
      FAIL: begin
        if (!lane.hs_enable) state_d = IDLE;
      end
    endcase
    if (state_d != LOCKED) begin
      off_d  = 1'b0;
      byte_d = '0;
    end
  end

  // History only runs while staying in HUNT/LOCKED; otherwise it is zero.
  always_comb begin
    run_q  = (state_q == HUNT) || (state_q == LOCKED);
    run_d  = (state_d == HUNT) || (state_d == LOCKED);
    hist_d = '0;
    if (run_q && run_d) hist_d = {lane.din, hist_q[15:2]};
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge dphy_clk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      hist_q  <= '0;
      cnt_q   <= '0;
      phase_q <= '0;
      off_q   <= 1'b0;
      byte_q  <= '0;
      bv_q    <= 1'b0;
      sf_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      off_q   <= off_d;
      byte_q  <= byte_d;
      bv_q    <= bv_d;
      sf_q    <= sf_d;
      se_q    <= se_d;
    end
  end

  assign lane.byte_out   = byte_q;
  assign lane.byte_valid = bv_q;
  assign lane.sync_found = sf_q;
  assign lane.locked     = (state_q == LOCKED);
  assign lane.bit_offset = off_q;
  assign lane.sync_err   = se_q;

endmodule
